logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_alu.sv | 27 ++
 rtl/logic_unit_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_NOT  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_t;

endpackage

// File: rtl/logic_unit_alu.sv
// Combinational bitwise core; NOT and PASS look only at operand a.
module logic_unit_alu
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic pipeline with an optional result accumulator.
// S1 holds the captured operands; S2 holds the registered result and its flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_t              s1_op;
    logic             s1_acc_en;
    logic [WIDTH-1:0] acc;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;

    // Handshake: in_ready depends only on stage state and out_ready, never on in_valid.
    always_comb begin
        s2_load  = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_load;
        s1_load  = in_valid && in_ready;
        alu_b    = s1_acc_en ? acc : s1_b;
    end

    logic_unit_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (s1_a),
        .b  (alu_b),
        .op (s1_op),
        .y  (alu_y)
    );

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_AND;
            s1_acc_en <= 1'b0;
        end else if (s1_load) begin
            s1_valid  <= 1'b1;
            s1_a      <= a;
            s1_b      <= b;
            s1_op     <= op_t'(op);
            s1_acc_en <= acc_en;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: result and flags, plus the accumulator that follows stream order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            acc       <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= alu_y;
            zero      <= ~|alu_y;
            parity    <= ^alu_y;
            acc       <= alu_y;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
